// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory-port arbiter: requester identity, lock states and ID FIFO entry.
package mem_port_arbiter_pkg;

  typedef enum logic {
    SRC_INST = 1'b0,
    SRC_DATA = 1'b1
  } src_e;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  typedef enum logic [1:0] {
    LK_IDLE = 2'd0,
    LK_INST = 2'd1,
    LK_DATA = 2'd2
  } lock_e;

  typedef struct packed {
    src_e src;
    logic discard;
  } id_entry_t;

endpackage

// File: rtl/mem_port_arbiter_src_id_fifo.sv
// In-order record of which requester owns each outstanding memory transaction.
module src_id_fifo
  import mem_port_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic push,
  input  logic push_src,
  input  logic push_discard,
  input  logic pop,
  input  logic flush,
  output logic head_src,
  output logic head_discard,
  output logic empty,
  output logic full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  id_entry_t   ent [DEPTH];

  // Explicit wrap keeps the top bit meaningful for any power-of-two depth, including 1.
  function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
    if (p[AW-1:0] == AW'(DEPTH - 1)) ptr_inc = {~p[AW], {AW{1'b0}}};
    else                             ptr_inc = p + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
    end
  end

  // Discarding free slots is harmless: they are overwritten on their next push.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (flush && ent[i].src == SRC_INST) ent[i].discard <= 1'b1;
      if (push && wr_ptr[AW-1:0] == AW'(i)) begin
        ent[i].src     <= src_e'(push_src);
        ent[i].discard <= push_discard;
      end
    end
  end

  assign empty        = (wr_ptr == rd_ptr);
  assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_src     = ent[rd_ptr[AW-1:0]].src;
  assign head_discard = ent[rd_ptr[AW-1:0]].discard;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one SRAM-like port between fetch and load/store, data-first with a fetch starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_OUT    = 2,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata,
  output logic        proto_err
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  lock_e         lk_q, lk_d;
  src_e          grant;
  logic [SW-1:0] starve_q;
  logic          proto_err_q;
  logic          accept;
  logic          pop;
  logic          fifo_full, fifo_empty;
  logic          head_src, head_discard;

  always_comb begin
    grant = SRC_INST;
    if (lk_q == LK_DATA)                                              grant = SRC_DATA;
    else if (lk_q == LK_INST)                                         grant = SRC_INST;
    else if (data_req && !(inst_req && starve_q == SW'(STARVE_LIM))) grant = SRC_DATA;
  end

  // Occupancy is registered so a same-cycle response never feeds back into mem_req.
  assign mem_req      = rstn && (inst_req || data_req) && !fifo_full;
  assign accept       = mem_req && mem_addr_ok;
  assign inst_addr_ok = accept && (grant == SRC_INST);
  assign data_addr_ok = accept && (grant == SRC_DATA);

  always_comb begin
    mem_wr    = 1'b0;
    mem_size  = SIZE_B;
    mem_wstrb = 4'd0;
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    if (mem_req) begin
      if (grant == SRC_DATA) begin
        mem_wr    = data_wr;
        mem_size  = data_size;
        mem_wstrb = data_wstrb;
        mem_addr  = data_addr;
        mem_wdata = data_wdata;
      end else begin
        mem_size  = SIZE_W;
        mem_addr  = inst_addr;
      end
    end
  end

  // Lock holds the grant on whichever side is presented but not yet accepted.
  always_ff @(posedge clk) begin
    if (!rstn) lk_q <= LK_IDLE;
    else       lk_q <= lk_d;
  end

  always_comb begin
    lk_d = lk_q;
    if (accept)       lk_d = LK_IDLE;
    else if (mem_req) lk_d = (grant == SRC_DATA) ? LK_DATA : LK_INST;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      starve_q    <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (!inst_req)
        starve_q <= '0;
      else if (inst_addr_ok)
        starve_q <= '0;
      else if (data_addr_ok && starve_q != SW'(STARVE_LIM))
        starve_q <= starve_q + 1'b1;
      if (mem_data_ok && fifo_empty) proto_err_q <= 1'b1;
    end
  end

  src_id_fifo #(
    .DEPTH(MAX_OUT)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push        (accept),
    .push_src    (grant),
    .push_discard(flush && grant == SRC_INST),
    .pop         (pop),
    .flush       (flush),
    .head_src    (head_src),
    .head_discard(head_discard),
    .empty       (fifo_empty),
    .full        (fifo_full)
  );

  assign pop          = rstn && mem_data_ok && !fifo_empty;
  assign inst_data_ok = pop && (head_src == SRC_INST) && !head_discard && !flush;
  assign data_data_ok = pop && (head_src == SRC_DATA);
  assign inst_rdata   = inst_data_ok ? mem_rdata : 32'd0;
  assign data_rdata   = data_data_ok ? mem_rdata : 32'd0;
  assign proto_err    = proto_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter with a spec-level reference model.
module tb_mem_port_arbiter;

  localparam int MAX_OUT    = 2;
  localparam int STARVE_LIM = 4;
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        proto_err;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MAX_OUT   (MAX_OUT),
    .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .flush       (flush),
    .inst_req    (inst_req),
    .inst_addr   (inst_addr),
    .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok),
    .inst_rdata  (inst_rdata),
    .data_req    (data_req),
    .data_wr     (data_wr),
    .data_size   (data_size),
    .data_wstrb  (data_wstrb),
    .data_addr   (data_addr),
    .data_wdata  (data_wdata),
    .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok),
    .data_rdata  (data_rdata),
    .mem_req     (mem_req),
    .mem_wr      (mem_wr),
    .mem_size    (mem_size),
    .mem_wstrb   (mem_wstrb),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_addr_ok (mem_addr_ok),
    .mem_data_ok (mem_data_ok),
    .mem_rdata   (mem_rdata),
    .proto_err   (proto_err)
  );

  typedef struct packed {
    logic        owner;
    logic        cancelled;
    logic [31:0] rdata;
  } mem_ent_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] rdata;
  } exp_t;

  mem_ent_t memq[$];
  exp_t     expq[$];

  int checks = 0;
  int errors = 0;

  bit model_en   = 1'b0;
  bit stop_new   = 1'b0;
  bit lk         = 1'b0;
  logic lk_src   = OWN_INST;
  int streak     = 0;
  int out_start  = 0;
  bit last_inst_ok = 1'b0;
  bit last_data_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of requester, flush and memory behaviour, applied just after the clock edge.
  task automatic drive_cycle();
    mem_ent_t e;
    if (inst_req && last_inst_ok) inst_req = 1'b0;
    if (!inst_req && !stop_new && $urandom_range(0, 3) != 0) begin
      inst_req  = 1'b1;
      inst_addr = $urandom;
    end
    if (data_req && last_data_ok) data_req = 1'b0;
    if (!data_req && !stop_new && $urandom_range(0, 7) != 0) begin
      data_req   = 1'b1;
      data_wr    = 1'($urandom_range(0, 1));
      data_size  = 2'($urandom_range(0, 2));
      data_wstrb = 4'($urandom);
      data_addr  = $urandom;
      data_wdata = $urandom;
    end
    flush = !stop_new && ($urandom_range(0, 15) == 0);
    if (flush) begin
      for (int i = 0; i < memq.size(); i++) begin
        e = memq[i];
        if (e.owner == OWN_INST) e.cancelled = 1'b1;
        memq[i] = e;
      end
    end
    out_start   = memq.size();
    mem_addr_ok = ($urandom_range(0, 3) != 0);
    if (memq.size() > 0 && $urandom_range(0, 1) == 1) begin
      e = memq.pop_front();
      mem_data_ok = 1'b1;
      mem_rdata   = e.rdata;
      if (!(e.owner == OWN_INST && e.cancelled)) expq.push_back('{owner: e.owner, rdata: e.rdata});
    end else begin
      mem_data_ok = 1'b0;
      mem_rdata   = $urandom;
    end
  endtask

  // Reference model: grant, lock and starvation rules evaluated on settled inputs.
  always @(negedge clk) begin
    bit   exp_req;
    bit   acc;
    logic g;
    last_inst_ok = inst_addr_ok;
    last_data_ok = data_addr_ok;
    if (model_en) begin
      exp_req = (inst_req || data_req) && (out_start < MAX_OUT);
      check("mem_req", {31'd0, mem_req}, {31'd0, exp_req});
      if (lk) g = lk_src;
      else if (data_req && !(inst_req && streak == STARVE_LIM)) g = OWN_DATA;
      else g = OWN_INST;
      acc = exp_req && mem_addr_ok;
      check("inst_addr_ok", {31'd0, inst_addr_ok}, {31'd0, acc && g == OWN_INST});
      check("data_addr_ok", {31'd0, data_addr_ok}, {31'd0, acc && g == OWN_DATA});
      if (exp_req) begin
        if (g == OWN_INST) begin
          check("mem_addr_inst", mem_addr, inst_addr);
          check("mem_cmd_inst", {25'd0, mem_wr, mem_size, mem_wstrb}, {25'd0, 1'b0, 2'd2, 4'd0});
        end else begin
          check("mem_addr_data", mem_addr, data_addr);
          check("mem_cmd_data", {25'd0, mem_wr, mem_size, mem_wstrb},
                {25'd0, data_wr, data_size, data_wstrb});
          check("mem_wdata", mem_wdata, data_wdata);
        end
      end
      if (acc) memq.push_back('{owner: g, cancelled: flush && g == OWN_INST, rdata: $urandom});
      if (acc) lk = 1'b0;
      else if (exp_req) begin
        lk     = 1'b1;
        lk_src = g;
      end
      if (!inst_req) streak = 0;
      else if (acc && g == OWN_INST) streak = 0;
      else if (acc && streak < STARVE_LIM) streak++;
    end
  end

  // Response monitor: every non-cancelled memory response must surface on its owner, same cycle.
  always @(negedge clk) begin
    exp_t e;
    if (inst_data_ok || data_data_ok) begin
      check("single_data_ok", {31'd0, inst_data_ok && data_data_ok}, 32'd0);
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_resp: got inst_data_ok=%0b data_data_ok=%0b expected none (t=%0t)",
                 inst_data_ok, data_data_ok, $time);
      end else begin
        e = expq.pop_front();
        check("resp_owner", {31'd0, data_data_ok}, {31'd0, e.owner});
        check("resp_rdata", data_data_ok ? data_rdata : inst_rdata, e.rdata);
      end
    end else if (expq.size() != 0) begin
      e = expq.pop_front();
      checks++;
      errors++;
      $display("FAIL missing_resp: got no data_ok expected owner=%0b rdata=%h (t=%0t)",
               e.owner, e.rdata, $time);
    end
  end

  initial begin
    bit drained;
    rstn = 1'b0; flush = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {25'd0, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok,
                          data_data_ok, proto_err, mem_wr}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("idle_outputs", {26'd0, mem_req, inst_addr_ok, data_addr_ok, inst_data_ok,
                           data_data_ok, proto_err}, 32'd0);

    @(posedge clk); #1;
    model_en = 1'b1;
    drive_cycle();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      drive_cycle();
    end

    stop_new = 1'b1;
    drained  = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      if (!inst_req && !data_req && memq.size() == 0 && expq.size() == 0) begin
        drained = 1'b1;
        break;
      end
      drive_cycle();
    end
    check("drain", {31'd0, drained}, 32'd1);
    mem_data_ok = 1'b0; mem_addr_ok = 1'b0; flush = 1'b0;
    inst_req = 1'b0; data_req = 1'b0;
    @(negedge clk);
    check("proto_err_clean", {31'd0, proto_err}, 32'd0);

    // Response with nothing outstanding.
    @(posedge clk); #1;
    mem_data_ok = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("stray_no_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    @(posedge clk); #1 mem_data_ok = 1'b0;
    @(negedge clk);
    check("proto_err_set", {31'd0, proto_err}, 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("proto_err_sticky", {31'd0, proto_err}, 32'd1);
    model_en = 1'b0;
    @(posedge clk); #1 rstn = 1'b0;
    @(posedge clk); #1 rstn = 1'b1;
    @(negedge clk);
    check("proto_err_rst", {31'd0, proto_err}, 32'd0);

    // Simultaneous requests after reset: data has priority.
    @(posedge clk); #1;
    inst_req = 1'b1; inst_addr = 32'h1C00_0000;
    data_req = 1'b1; data_addr = 32'h0000_8000; data_wr = 1'b0;
    data_size = 2'd2; data_wstrb = 4'd0; mem_addr_ok = 1'b1;
    @(negedge clk);
    check("both_data_ok", {30'd0, data_addr_ok, inst_addr_ok}, 32'd2);
    check("both_mem_addr", mem_addr, 32'h0000_8000);
    @(posedge clk); #1;
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0;
    @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
